// File: rtl/thor2022_cond_eval_if.sv
// Request/result bundle for the compare-vector condition evaluator.
// The master modport drives requests and consumes results; the slave is the evaluator.
interface thor2022_cond_eval_if #(
  parameter int CW    = 128,
  parameter int SELW  = 7,
  parameter int TAGW  = 4,
  parameter int DEPTH = 2
);
  localparam int CNTW = $clog2(DEPTH + 1) + 1;

  logic            flush_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [CW-1:0]   cmp_i;
  logic [SELW-1:0] sel_i;
  logic            neg_i;
  logic [TAGW-1:0] tag_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic            res_taken_o;
  logic            res_undef_o;
  logic [TAGW-1:0] res_tag_o;
  logic [CNTW-1:0] count_o;

  modport master (
    output flush_i, req_valid_i, cmp_i, sel_i, neg_i, tag_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_taken_o, res_undef_o, res_tag_o, count_o
  );

  modport slave (
    input  flush_i, req_valid_i, cmp_i, sel_i, neg_i, tag_i, res_ready_i,
    output req_ready_o, res_valid_o, res_taken_o, res_undef_o, res_tag_o, count_o
  );
endinterface

// File: rtl/thor2022_cond_eval.sv
// Selects one bit of a compare-result vector, optionally negates it, and returns a tagged
// taken/undef outcome through a single eval register and a credit-controlled result FIFO.
module thor2022_cond_eval #(
  parameter int CW    = 128,
  parameter int SELW  = 7,
  parameter int TAGW  = 4,
  parameter int DEPTH = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  thor2022_cond_eval_if.slave bus
);
  localparam int CNTW = $clog2(DEPTH + 1) + 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            taken;
    logic            undef;
    logic [TAGW-1:0] tag;
  } res_t;

  // Integer compare flags at 0..2, 5, 6, 8..10; DFP flags at 32..41.
  function automatic logic [CW-1:0] def_mask_f();
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < CW; i++) begin
      if (i <= 2 || i == 5 || i == 6 || (i >= 8 && i <= 10) || (i >= 32 && i <= 41))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [CW-1:0] DEF_MASK = def_mask_f();

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic            clear;
  logic [CNTW-1:0] occupancy;
  logic            req_ready;
  logic            accept;
  logic            res_valid;
  logic            pop;
  res_t            new_res;
  res_t            head;

  logic            eval_valid;
  res_t            eval_res;
  res_t            mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] fifo_count;

  always_comb begin
    // NOTE: every variable gets a default before any conditional use, so no latch is inferred.
    new_res       = '0;
    new_res.tag   = bus.tag_i;
    new_res.undef = ~DEF_MASK[bus.sel_i];
    if (DEF_MASK[bus.sel_i]) new_res.taken = bus.cmp_i[bus.sel_i] ^ bus.neg_i;
  end

  // Reset behaves as a flush; the credit check ignores same-cycle pops on purpose so that
  // req_ready depends only on registered state plus the flush/reset inputs.
  assign clear     = rst_i | bus.flush_i;
  assign occupancy = fifo_count + CNTW'(eval_valid);
  assign req_ready = ~clear & (occupancy < CNTW'(DEPTH));
  assign accept    = bus.req_valid_i & req_ready;
  assign res_valid = (fifo_count != '0);
  assign pop       = res_valid & bus.res_ready_i;
  assign head      = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      eval_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      eval_valid <= accept;
      if (eval_valid) wr_ptr <= ptr_next(wr_ptr);
      if (pop)        rd_ptr <= ptr_next(rd_ptr);
      fifo_count <= fifo_count + CNTW'(eval_valid) - CNTW'(pop);
    end
  end

  // NOTE: payload storage carries no reset; valid/count gate every use of it.
  always_ff @(posedge clk_i) begin
    if (accept) eval_res <= new_res;
    if (eval_valid && !clear) mem[wr_ptr] <= eval_res;
  end

  assign bus.req_ready_o = req_ready;
  assign bus.res_valid_o = res_valid;
  assign bus.res_taken_o = res_valid & head.taken;
  assign bus.res_undef_o = res_valid & head.undef;
  assign bus.res_tag_o   = res_valid ? head.tag : '0;
  assign bus.count_o     = occupancy;
endmodule

// File: tb/tb_thor2022_cond_eval.sv
// Directed bench for thor2022_cond_eval: a scoreboard queue is filled on each accepted request
// and drained as results are popped, alongside explicit checks of latency, credit and flush.
module tb_thor2022_cond_eval;
  localparam int CW = 128, SELW = 7, TAGW = 4, DEPTH = 2;

  typedef struct packed {
    logic            taken;
    logic            undef;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   accepts = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  thor2022_cond_eval_if #(.CW(CW), .SELW(SELW), .TAGW(TAGW), .DEPTH(DEPTH)) bus ();

  thor2022_cond_eval #(.CW(CW), .SELW(SELW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [CW-1:0] c, input logic [SELW-1:0] s,
                                 input logic n, input logic [TAGW-1:0] t);
    exp_t e;
    logic d;
    d = (s == 7'd0) || (s == 7'd1) || (s == 7'd2) || (s == 7'd5) || (s == 7'd6) ||
        (s == 7'd8) || (s == 7'd9) || (s == 7'd10) || (s >= 7'd32 && s <= 7'd41);
    e.tag   = t;
    e.undef = ~d;
    e.taken = d ? (c[s] ^ n) : 1'b0;
    return e;
  endfunction

  // Handshakes are resolved mid-cycle, when inputs driven after the previous edge are stable.
  always @(negedge clk) begin
    if (rst || bus.flush_i) begin
      sb.delete();
    end else begin
      if (bus.res_valid_o && bus.res_ready_i) begin
        pops++;
        if (sb.size() == 0) begin
          check("pop_unexpected", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {bus.res_taken_o, bus.res_undef_o, bus.res_tag_o}, e);
        end
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        accepts++;
        sb.push_back(model(bus.cmp_i, bus.sel_i, bus.neg_i, bus.tag_i));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [SELW-1:0] s,
                      input logic n, input logic [TAGW-1:0] t);
    int w;
    w = 0;
    while (!bus.req_ready_o && w < 20) begin
      step();
      w++;
    end
    check("send_ready", bus.req_ready_o, 1'b1);
    bus.cmp_i = c;
    bus.sel_i = s;
    bus.neg_i = n;
    bus.tag_i = t;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.res_ready_i = 1'b1;
    while (bus.count_o != 0 && w < 20) begin
      step();
      w++;
    end
    check("drain_count", bus.count_o, 0);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, bus.res_valid_o, 1'b0);
    check({tag, "_taken"}, bus.res_taken_o, 1'b0);
    check({tag, "_undef"}, bus.res_undef_o, 1'b0);
    check({tag, "_tag"},   bus.res_tag_o, 0);
    check({tag, "_count"}, bus.count_o, 0);
    check({tag, "_ready"}, bus.req_ready_o, 1'b1);
  endtask

  initial begin
    logic [CW-1:0] v;
    int n_acc;
    int w;
    int acc_start;

    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.cmp_i = '0;
    bus.sel_i = '0;
    bus.neg_i = 1'b0;
    bus.tag_i = '0;
    bus.res_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Eq bit, two-edge latency.
    bus.cmp_i = 128'h1;
    bus.sel_i = 7'd0;
    bus.neg_i = 1'b0;
    bus.tag_i = 4'd3;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    check("lat1_valid", bus.res_valid_o, 1'b0);
    check("lat1_count", bus.count_o, 1);
    step();
    check("lat2_valid", bus.res_valid_o, 1'b1);
    check("lat2_taken", bus.res_taken_o, 1'b1);
    check("lat2_undef", bus.res_undef_o, 1'b0);
    check("lat2_tag",   bus.res_tag_o, 4'd3);
    drain();

    // DFP flag with negation, undefined selectors, negated clear bit.
    v = '0;
    v[39] = 1'b1;
    bus.res_ready_i = 1'b1;
    send(v, 7'd39, 1'b1, 4'd5);
    send(v, 7'd3, 1'b1, 4'd6);
    send(128'h8, 7'd3, 1'b0, 4'd7);
    send(128'h0, 7'd1, 1'b1, 4'd8);
    send(v, 7'd39, 1'b0, 4'd9);
    send(128'hFFFF, 7'd11, 1'b1, 4'd10);
    drain();

    // Credit: two results fill the FIFO with the consumer stalled; head holds steady.
    bus.res_ready_i = 1'b0;
    send(128'h4, 7'd2, 1'b0, 4'd1);
    send(128'h0, 7'd2, 1'b0, 4'd2);
    check("full_ready", bus.req_ready_o, 1'b0);
    check("full_count", bus.count_o, 2);
    step();
    check("hold_tag",   bus.res_tag_o, 4'd1);
    check("hold_taken", bus.res_taken_o, 1'b1);
    check("hold_ready", bus.req_ready_o, 1'b0);
    step();
    check("hold_tag2",  bus.res_tag_o, 4'd1);
    drain();

    // Streaming with consumer always ready: no loss, no reorder, occupancy never above DEPTH.
    bus.res_ready_i = 1'b1;
    n_acc = 0;
    w = 0;
    acc_start = accepts;
    while (n_acc < 20 && w < 200) begin
      bus.cmp_i = {$urandom, $urandom, $urandom, $urandom};
      bus.sel_i = ($urandom_range(0, 1) == 0) ? SELW'($urandom_range(32, 41)) : SELW'($urandom_range(0, 15));
      bus.neg_i = 1'($urandom_range(0, 1));
      bus.tag_i = TAGW'(n_acc);
      bus.req_valid_i = 1'b1;
      if (bus.req_ready_o) n_acc++;
      step();
      check("stream_occ", (bus.count_o <= 2), 1'b1);
      w++;
    end
    bus.req_valid_i = 1'b0;
    check("stream_accepts", accepts - acc_start, 20);
    drain();

    // Flush with eval stage and FIFO both occupied; a request offered during flush is dropped.
    bus.res_ready_i = 1'b0;
    send(128'h1, 7'd0, 1'b0, 4'd7);
    send(128'h1, 7'd0, 1'b0, 4'd8);
    bus.flush_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.tag_i = 4'd9;
    bus.res_ready_i = 1'b1;
    #1;
    check("flush_ready_low", bus.req_ready_o, 1'b0);
    step();
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.res_ready_i = 1'b0;
    #1;
    check("flush_valid", bus.res_valid_o, 1'b0);
    check("flush_count", bus.count_o, 0);
    check("flush_ready", bus.req_ready_o, 1'b1);
    step();
    check("flush_dropped", bus.count_o, 0);

    // Reset mid-stream, then a fresh request with two-edge latency.
    send(128'h2, 7'd1, 1'b0, 4'd4);
    send(128'h2, 7'd1, 1'b1, 4'd5);
    rst = 1'b1;
    bus.req_valid_i = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    check_reset_state("rst_mid");
    bus.cmp_i = '0;
    bus.cmp_i[41] = 1'b1;
    bus.sel_i = 7'd41;
    bus.neg_i = 1'b0;
    bus.tag_i = 4'hA;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    check("rst_lat1_valid", bus.res_valid_o, 1'b0);
    step();
    check("rst_lat2_valid", bus.res_valid_o, 1'b1);
    check("rst_lat2_tag",   bus.res_tag_o, 4'hA);
    check("rst_lat2_taken", bus.res_taken_o, 1'b1);
    drain();

    step();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
